// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment display driver: sequential binary-to-BCD conversion,
// leading-zero blanking, overflow dashes. Optional flashing via `SEG_BLINK_EN`.
module seg_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1,
  parameter int BLINK_TICKS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
`ifdef SEG_BLINK_EN
  input  logic                  blink,
`endif
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  // Accumulator is wide enough for the full input range so wide values convert exactly.
  localparam int BCD_N = ((VALUE_W / 3 + 1) > NUM_DIGITS) ? (VALUE_W / 3 + 1) : NUM_DIGITS;
  localparam int BCD_W = 4 * BCD_N;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] MAX_C = 64'(10 ** NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                    state_r, state_nxt_s;
  logic [VALUE_W-1:0]        val_r;
  logic [BCD_W-1:0]          bcd_r, bcd_adj_s;
  logic [CNT_W-1:0]          bit_cnt_r;
  logic                      ovf_cap_r;
  logic [4*NUM_DIGITS-1:0]   disp_r;
  logic [REF_W-1:0]          ref_cnt_r;
  logic                      tick_s;
  logic [DIG_W-1:0]          dig_r, dig_nxt_s;
  logic [NUM_DIGITS-1:0]     blank_s;
  logic                      nz_s;
  logic [3:0]                nib_s;
  logic [6:0]                seg_nxt_s;
  logic [NUM_DIGITS-1:0]     an_nxt_s;
  logic                      dark_s;

  function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Conversion state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Conversion next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load) state_nxt_s = ST_SHIFT;
        else      state_nxt_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (bit_cnt_r == CNT_W'(VALUE_W - 1)) state_nxt_s = ST_DONE;
        else                                  state_nxt_s = ST_SHIFT;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Add-3 correction of every BCD nibble before the next shift
  always_comb begin
    bcd_adj_s = bcd_r;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd_r[i*4 +: 4] >= 4'd5) bcd_adj_s[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
      else                         bcd_adj_s[i*4 +: 4] = bcd_r[i*4 +: 4];
    end
  end

  // Conversion datapath, display register and handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_r     <= '0;
      bcd_r     <= '0;
      bit_cnt_r <= '0;
      ovf_cap_r <= 1'b0;
      disp_r    <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            val_r     <= value;
            bcd_r     <= '0;
            bit_cnt_r <= '0;
            ovf_cap_r <= (64'(value) > MAX_C);
          end
        end
        ST_SHIFT: begin
          bcd_r     <= {bcd_adj_s[BCD_W-2:0], val_r[VALUE_W-1]};
          val_r     <= {val_r[VALUE_W-2:0], 1'b0};
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end
        ST_DONE: begin
          disp_r   <= bcd_r[4*NUM_DIGITS-1:0];
          overflow <= ovf_cap_r;
        end
        default: begin
          bcd_r <= '0;
        end
      endcase
    end
  end

  assign tick_s    = (ref_cnt_r == REF_W'(REFRESH_DIV - 1));
  assign dig_nxt_s = (dig_r == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_r + DIG_W'(1);
  assign nib_s     = disp_r[dig_nxt_s*4 +: 4];

  // A digit is blank when it and every more significant digit is zero
  always_comb begin
    nz_s    = 1'b0;
    blank_s = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nz_s = nz_s | (disp_r[k*4 +: 4] != 4'd0);
      if ((BLANK_LZ != 0) && (k != 0) && !nz_s) blank_s[k] = 1'b1;
      else                                      blank_s[k] = 1'b0;
    end
  end

  // Segment/anode values for the slot that begins at the next refresh tick
  always_comb begin
    seg_nxt_s = 7'h7F;
    an_nxt_s  = {NUM_DIGITS{1'b1}};
    if (!enable || dark_s) begin
      seg_nxt_s = 7'h7F;
      an_nxt_s  = {NUM_DIGITS{1'b1}};
    end else if (overflow) begin
      seg_nxt_s = 7'b0111111;
      an_nxt_s  = ~(NUM_DIGITS'(1) << dig_nxt_s);
    end else if (blank_s[dig_nxt_s]) begin
      seg_nxt_s = 7'h7F;
      an_nxt_s  = {NUM_DIGITS{1'b1}};
    end else begin
      seg_nxt_s = seg_pattern(nib_s);
      an_nxt_s  = ~(NUM_DIGITS'(1) << dig_nxt_s);
    end
  end

  // Refresh counter, digit index and registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_r <= '0;
      dig_r     <= '0;
      seg       <= 7'h7F;
      an        <= {NUM_DIGITS{1'b1}};
    end else if (tick_s) begin
      ref_cnt_r <= '0;
      dig_r     <= dig_nxt_s;
      seg       <= seg_nxt_s;
      an        <= an_nxt_s;
    end else begin
      ref_cnt_r <= ref_cnt_r + REF_W'(1);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  logic [BLK_W-1:0] blk_cnt_r;
  logic             phase_r;

  // Blink phase toggles after every BLINK_TICKS slot advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_r <= '0;
      phase_r   <= 1'b0;
    end else if (tick_s) begin
      if (blk_cnt_r == BLK_W'(BLINK_TICKS - 1)) begin
        blk_cnt_r <= '0;
        phase_r   <= ~phase_r;
      end else begin
        blk_cnt_r <= blk_cnt_r + BLK_W'(1);
      end
    end
  end

  assign dark_s = blink & phase_r;
`else
  assign dark_s = 1'b0;
`endif

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux: expected scan frames are queued at load time
// and compared slot by slot against the multiplexed outputs.
module tb_seg_display_mux;

  localparam int ND = 4;
  localparam int VW = 14;
  localparam int RD = 4;

  typedef struct packed {
    logic [27:0] segs;
    logic [15:0] ans;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst, enable, load, load_nb, blink;
  logic [VW-1:0] value;
  logic          busy_a, ovf_a, busy_nb, ovf_nb;
  logic [6:0]    seg_a, seg_nb;
  logic [ND-1:0] an_a, an_nb;

  frame_t sb_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  always #5 clk = ~clk;

  seg_display_mux #(.NUM_DIGITS(ND), .VALUE_W(VW), .REFRESH_DIV(RD), .BLANK_LZ(1), .BLINK_TICKS(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .value(value), .load(load),
`ifdef SEG_BLINK_EN
    .blink(blink),
`endif
    .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .an(an_a));

  seg_display_mux #(.NUM_DIGITS(ND), .VALUE_W(VW), .REFRESH_DIV(RD), .BLANK_LZ(0), .BLINK_TICKS(2)) dut_nb (
    .clk(clk), .rst(rst), .enable(enable), .value(value), .load(load_nb),
`ifdef SEG_BLINK_EN
    .blink(blink),
`endif
    .busy(busy_nb), .overflow(ovf_nb), .seg(seg_nb), .an(an_nb));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_pat(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected per-slot pins from arithmetic decimal digits
  function automatic frame_t make_frame(input int v, input bit blank_lz);
    frame_t f;
    int q;
    q = v;
    for (int k = 0; k < ND; k++) begin
      if (v > 9999) begin
        f.segs[k*7 +: 7] = 7'b0111111;
        f.ans[k*4 +: 4]  = ~(4'b0001 << k);
      end else if (blank_lz && k > 0 && q == 0) begin
        f.segs[k*7 +: 7] = 7'h7F;
        f.ans[k*4 +: 4]  = 4'hF;
      end else begin
        f.segs[k*7 +: 7] = ref_pat(q % 10);
        f.ans[k*4 +: 4]  = ~(4'b0001 << k);
      end
      q = q / 10;
    end
    return f;
  endfunction

  function automatic logic [3:0] an_of(input bit nb);
    return nb ? an_nb : an_a;
  endfunction

  function automatic logic [6:0] seg_of(input bit nb);
    return nb ? seg_nb : seg_a;
  endfunction

  task automatic pulse_load(input int v, input bit nb);
    @(negedge clk);
    value = VW'(v);
    if (nb) load_nb = 1'b1; else load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    load_nb = 1'b0;
  endtask

  task automatic wait_idle(input bit nb, output int n);
    n = 0;
    while ((nb ? busy_nb : busy_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("busy_timeout", 32'd1, 32'd0);
  endtask

  // Pop the oldest expected frame and compare one full scan starting at slot 0
  task automatic check_frame(input bit nb, input string tag);
    frame_t f;
    int n;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    f = sb_q.pop_front();
    n = 0;
    while (an_of(nb) == 4'hE && n < 64) begin @(negedge clk); n++; end
    while (an_of(nb) != 4'hE && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) begin
      check({tag, "_sync_timeout"}, 32'd1, 32'd0);
      return;
    end
    for (int k = 0; k < ND; k++) begin
      check($sformatf("%s_seg%0d", tag, k), 32'(seg_of(nb)), 32'(f.segs[k*7 +: 7]));
      check($sformatf("%s_an%0d", tag, k), 32'(an_of(nb)), 32'(f.ans[k*4 +: 4]));
      repeat (RD) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int lit;
    rst = 1'b1; enable = 1'b0; load = 1'b0; load_nb = 1'b0; blink = 1'b0; value = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    pulse_load(77, 1'b0);
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-run
    rst = 1'b1;
    #1;
    check("rst_seg", 32'(seg_a), 32'h7F);
    check("rst_an", 32'(an_a), 32'hF);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    repeat (12) @(negedge clk);
    check("disabled_an", 32'(an_a), 32'hF);
    enable = 1'b1;

    // 42: busy length then scan
    sb_q.push_back(make_frame(42, 1'b1));
    pulse_load(42, 1'b0);
    n = 0;
    while (busy_a && n < 100) begin n++; @(negedge clk); end
    check("busy_cycles", 32'(n), 32'd15);
    check_frame(1'b0, "v42");

    // 1234 followed by an ignored load of 9
    sb_q.push_back(make_frame(1234, 1'b1));
    pulse_load(1234, 1'b0);
    @(negedge clk);
    pulse_load(9, 1'b0);
    wait_idle(1'b0, n);
    check_frame(1'b0, "v1234");

    sb_q.push_back(make_frame(0, 1'b1));
    pulse_load(0, 1'b0);
    wait_idle(1'b0, n);
    check_frame(1'b0, "v0");

    sb_q.push_back(make_frame(10000, 1'b1));
    pulse_load(10000, 1'b0);
    wait_idle(1'b0, n);
    check("ovf_set", 32'(ovf_a), 32'd1);
    check_frame(1'b0, "v10000");

    sb_q.push_back(make_frame(9999, 1'b1));
    pulse_load(9999, 1'b0);
    wait_idle(1'b0, n);
    check("ovf_clr", 32'(ovf_a), 32'd0);
    check_frame(1'b0, "v9999");

    sb_q.push_back(make_frame(7, 1'b0));
    pulse_load(7, 1'b1);
    wait_idle(1'b1, n);
    check_frame(1'b1, "nb_v7");

    // Reset during conversion aborts it and clears the display
    pulse_load(555, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_shift_busy", 32'(busy_a), 32'd0);
    check("rst_shift_seg", 32'(seg_a), 32'h7F);
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(make_frame(0, 1'b1));
    check_frame(1'b0, "after_rst");

`ifdef SEG_BLINK_EN
    // dut_nb shows 0000 with all digits lit; blinking darkens half the slots
    blink = 1'b1;
    repeat (RD * 2) @(negedge clk);
    lit = 0;
    for (int s = 0; s < 8; s++) begin
      if (an_nb != 4'hF) lit++;
      repeat (RD) @(negedge clk);
    end
    check("blink_lit", 32'(lit), 32'd4);
    blink = 1'b0;
    repeat (RD * 2) @(negedge clk);
    lit = 0;
    for (int s = 0; s < 8; s++) begin
      if (an_nb != 4'hF) lit++;
      repeat (RD) @(negedge clk);
    end
    check("noblink_lit", 32'(lit), 32'd8);
`else
    lit = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
